// File: rtl/vending_machine_param.sv
// Card-operated vending controller: two-digit BCD selection, bank approval,
// door handshake, and per-slot stock counters.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a card or a restock request
// RELOADING  | stock counters just reloaded, return to IDLE next cycle
// WAIT_KEY1  | waiting for release of the tens-digit key
// WAIT_KEY2  | waiting for release of the units-digit key
// CHECK      | validate digits, code range and slot stock
// WAIT_TRAN  | price shown, waiting for bank approval
// WAIT_OPEN  | dispensing enabled, waiting for the customer to open door
// WAIT_CLOSE | door open, waiting for it to close (no timeout)
// INVALID    | one-cycle bad-selection indication
// FAILED     | one-cycle failed-transaction indication
module vending_machine_param #(
    parameter int NUM_ITEMS  = 20,
    parameter int ITEM_DEPTH = 10,
    parameter int TIMEOUT    = 5,
    parameter int COST_STEP  = 4,
    parameter int COST_W     = 3
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CARD_IN,
    input  logic              VALID_TRAN,
    input  logic              KEY_PRESS,
    input  logic              DOOR_OPEN,
    input  logic              RELOAD,
    input  logic [3:0]        ITEM_CODE,
    output logic              VEND,
    output logic              INVALID_SEL,
    output logic              FAILED_TRAN,
    output logic [COST_W-1:0] COST
);

    localparam int STOCK_W  = (ITEM_DEPTH < 1) ? 1 : $clog2(ITEM_DEPTH + 1);
    localparam int CNT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int COST_MAX = (1 << COST_W) - 1;
    localparam logic [7:0] NUM_CODE = 8'(NUM_ITEMS);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_RELOADING  = 4'd1;
    localparam logic [3:0] S_WAIT_KEY1  = 4'd2;
    localparam logic [3:0] S_WAIT_KEY2  = 4'd3;
    localparam logic [3:0] S_CHECK      = 4'd4;
    localparam logic [3:0] S_WAIT_TRAN  = 4'd5;
    localparam logic [3:0] S_WAIT_OPEN  = 4'd6;
    localparam logic [3:0] S_WAIT_CLOSE = 4'd7;
    localparam logic [3:0] S_INVALID    = 4'd8;
    localparam logic [3:0] S_FAILED     = 4'd9;

    logic [3:0]         state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic               wait_hit;
    logic               key_prev, key_rel;
    logic [3:0]         tens, units;
    logic [7:0]         code_full;
    logic               sel_ok;
    logic [STOCK_W-1:0] sel_stock;
    logic [STOCK_W-1:0] stock [NUM_ITEMS];
    logic               reload_en, dec_en;
    logic               priced;
    int                 price_i;
    logic [COST_W-1:0]  price;

    assign wait_hit  = (wait_cnt == CNT_W'(TIMEOUT));
    assign key_rel   = key_prev & ~KEY_PRESS;
    assign code_full = 8'(tens) * 8'd10 + 8'(units);
    assign reload_en = (state == S_IDLE) && RELOAD;
    assign dec_en    = (state == S_WAIT_CLOSE) && !DOOR_OPEN;

    // stock of the slot addressed by the captured digits (0 if out of range)
    always_comb begin
        sel_stock = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (code_full == 8'(i)) sel_stock = stock[i];
        end
    end

    // selection is good only for BCD digits, an existing slot, and stock left
    always_comb begin
        sel_ok = (tens <= 4'd9) && (units <= 4'd9) &&
                 (code_full < NUM_CODE) && (sel_stock != '0);
    end

    // price band of the selected code, saturating at the COST field maximum
    always_comb begin
        price_i = int'(code_full) / COST_STEP + 1;
        price   = (price_i > COST_MAX) ? COST_W'(COST_MAX) : COST_W'(price_i);
    end

    // next-state decision; card removal beats any event while a card matters
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (RELOAD)       state_nxt = S_RELOADING;
                else if (CARD_IN) state_nxt = S_WAIT_KEY1;
            end
            S_RELOADING: state_nxt = S_IDLE;
            S_WAIT_KEY1: begin
                if (!CARD_IN)     state_nxt = S_IDLE;
                else if (key_rel) state_nxt = S_WAIT_KEY2;
                else if (wait_hit) state_nxt = S_FAILED;
            end
            S_WAIT_KEY2: begin
                if (!CARD_IN)     state_nxt = S_IDLE;
                else if (key_rel) state_nxt = S_CHECK;
                else if (wait_hit) state_nxt = S_FAILED;
            end
            S_CHECK: state_nxt = sel_ok ? S_WAIT_TRAN : S_INVALID;
            S_WAIT_TRAN: begin
                if (!CARD_IN)        state_nxt = S_IDLE;
                else if (VALID_TRAN) state_nxt = S_WAIT_OPEN;
                else if (wait_hit)   state_nxt = S_FAILED;
            end
            S_WAIT_OPEN: begin
                if (DOOR_OPEN)     state_nxt = S_WAIT_CLOSE;
                else if (wait_hit) state_nxt = S_IDLE;
            end
            S_WAIT_CLOSE: begin
                if (!DOOR_OPEN) state_nxt = S_IDLE;
            end
            S_INVALID: state_nxt = S_IDLE;
            S_FAILED:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // wait counter restarts on every state change, so each wait state sees a fresh count
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                wait_cnt <= '0;
        else if (state_nxt != state) wait_cnt <= '0;
        else if (!wait_hit)          wait_cnt <= wait_cnt + 1'b1;
    end

    // previous key level for release-edge detection
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) key_prev <= 1'b0;
        else          key_prev <= KEY_PRESS;
    end

    // digit capture on the key release that advances the selection
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tens  <= '0;
            units <= '0;
        end else begin
            if (state == S_WAIT_KEY1 && state_nxt == S_WAIT_KEY2) tens  <= ITEM_CODE;
            if (state == S_WAIT_KEY2 && state_nxt == S_CHECK)     units <= ITEM_CODE;
        end
    end

    // stock counters: full reload from IDLE, single decrement on door close
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= '0;
        end else if (reload_en) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(ITEM_DEPTH);
        end else if (dec_en) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (code_full == 8'(i) && stock[i] != '0) stock[i] <= stock[i] - 1'b1;
            end
        end
    end

    // priced: the selection passed CHECK and the machine has not yet returned to IDLE
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) priced <= 1'b0;
        else priced <= (state_nxt == S_WAIT_TRAN) || (state_nxt == S_WAIT_OPEN) ||
                       (state_nxt == S_WAIT_CLOSE) ||
                       (state_nxt == S_FAILED && state == S_WAIT_TRAN);
    end

    // registered outputs, one cycle behind the state they reflect
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            VEND        <= 1'b0;
            INVALID_SEL <= 1'b0;
            FAILED_TRAN <= 1'b0;
            COST        <= '0;
        end else begin
            VEND        <= (state == S_WAIT_OPEN) || (state == S_WAIT_CLOSE);
            INVALID_SEL <= (state == S_INVALID);
            FAILED_TRAN <= (state == S_FAILED);
            COST        <= priced ? price : '0;
        end
    end

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: a transaction-level model predicts what the
// outputs and stock must be; a compare process checks them every cycle.
module tb_vending_machine_param;

    localparam int NUM_ITEMS  = 20;
    localparam int ITEM_DEPTH = 10;
    localparam int TIMEOUT    = 5;
    localparam int COST_STEP  = 4;
    localparam int COST_W     = 3;
    localparam int COST_MAX   = (1 << COST_W) - 1;

    typedef enum int {EV_HIT, EV_ABORT, EV_TIMEOUT, EV_RESET} ev_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              card_in = 1'b0, valid_tran = 1'b0, key_press = 1'b0;
    logic              door_open = 1'b0, reload = 1'b0;
    logic [3:0]        item_code = 4'd0;
    logic              vend, invalid_sel, failed_tran;
    logic [COST_W-1:0] cost;

    int n_checks = 0;
    int n_errors = 0;

    vending_machine_param #(
        .NUM_ITEMS(NUM_ITEMS), .ITEM_DEPTH(ITEM_DEPTH), .TIMEOUT(TIMEOUT),
        .COST_STEP(COST_STEP), .COST_W(COST_W)
    ) dut (
        .CLK(clk), .RESET_N(reset_n), .CARD_IN(card_in), .VALID_TRAN(valid_tran),
        .KEY_PRESS(key_press), .DOOR_OPEN(door_open), .RELOAD(reload),
        .ITEM_CODE(item_code), .VEND(vend), .INVALID_SEL(invalid_sel),
        .FAILED_TRAN(failed_tran), .COST(cost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    int m_stock [NUM_ITEMS];
    bit m_vend, m_inv, m_fail;
    int m_cost;
    bit exp_vend, exp_inv, exp_fail;
    int exp_cost;
    bit key_now, key_last;

    // what the machine shows this cycle appears on the outputs one cycle later
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_vend <= 0; exp_inv <= 0; exp_fail <= 0; exp_cost <= 0;
        end else begin
            exp_vend <= m_vend; exp_inv <= m_inv; exp_fail <= m_fail; exp_cost <= m_cost;
        end
    end

    always @(negedge reset_n) begin
        foreach (m_stock[i]) m_stock[i] = 0;
        m_vend <= 0; m_inv <= 0; m_fail <= 0; m_cost <= 0;
        key_now = 0;
    end

    task automatic show(input bit v, input int c, input bit inv, input bit fl);
        m_vend <= v; m_cost <= c; m_inv <= inv; m_fail <= fl;
    endtask

    task automatic mclk(output bit rst);
        key_last = key_now;
        @(posedge clk);
        key_now = reset_n ? key_press : 1'b0;
        rst = !reset_n;
    endtask

    // wait up to TIMEOUT+1 clocks for an event: 0 key release, 1 approval, 2 door open
    task automatic model_wait(input int kind, input bit card_matters, output ev_t ev);
        bit r;
        ev = EV_TIMEOUT;
        for (int n = 0; n <= TIMEOUT; n++) begin
            mclk(r);
            if (r) begin ev = EV_RESET; return; end
            if (card_matters && !card_in) begin ev = EV_ABORT; return; end
            if ((kind == 0 && key_last && !key_now) || (kind == 1 && valid_tran) ||
                (kind == 2 && door_open)) begin
                ev = EV_HIT;
                return;
            end
        end
    endtask

    task automatic model_tx();
        bit r;
        ev_t ev;
        int tens, units, code, price;
        mclk(r);
        if (r) return;
        if (reload) begin
            foreach (m_stock[i]) m_stock[i] = ITEM_DEPTH;
            mclk(r);
            return;
        end
        if (!card_in) return;
        model_wait(0, 1, ev);
        if (ev == EV_RESET) return;
        if (ev == EV_ABORT) return;
        if (ev == EV_TIMEOUT) begin show(0, 0, 0, 1); mclk(r); if (!r) show(0, 0, 0, 0); return; end
        tens = item_code;
        model_wait(0, 1, ev);
        if (ev == EV_RESET) return;
        if (ev == EV_ABORT) return;
        if (ev == EV_TIMEOUT) begin show(0, 0, 0, 1); mclk(r); if (!r) show(0, 0, 0, 0); return; end
        units = item_code;
        mclk(r);
        if (r) return;
        code = 10 * tens + units;
        if (tens > 9 || units > 9 || code >= NUM_ITEMS || m_stock[code] == 0) begin
            show(0, 0, 1, 0); mclk(r); if (!r) show(0, 0, 0, 0);
            return;
        end
        price = code / COST_STEP + 1;
        if (price > COST_MAX) price = COST_MAX;
        show(0, price, 0, 0);
        model_wait(1, 1, ev);
        if (ev == EV_RESET) return;
        if (ev == EV_ABORT) begin show(0, 0, 0, 0); return; end
        if (ev == EV_TIMEOUT) begin show(0, price, 0, 1); mclk(r); if (!r) show(0, 0, 0, 0); return; end
        show(1, price, 0, 0);
        model_wait(2, 0, ev);
        if (ev == EV_RESET) return;
        if (ev == EV_TIMEOUT) begin show(0, 0, 0, 0); return; end
        do begin
            mclk(r);
            if (r) return;
        end while (door_open);
        if (m_stock[code] > 0) m_stock[code]--;
        show(0, 0, 0, 0);
    endtask

    initial forever model_tx();

    // ---------------- compare + observation ----------------
    int obs_vend, obs_inv, obs_fail, obs_cost_cyc, obs_max_cost;

    task automatic clear_obs();
        obs_vend = 0; obs_inv = 0; obs_fail = 0; obs_cost_cyc = 0; obs_max_cost = 0;
    endtask

    // every cycle: outputs and stock against the model
    always @(negedge clk) begin
        int bad_slot;
        chk("VEND", int'(vend), int'(exp_vend));
        chk("INVALID_SEL", int'(invalid_sel), int'(exp_inv));
        chk("FAILED_TRAN", int'(failed_tran), int'(exp_fail));
        chk("COST", int'(cost), exp_cost);
        bad_slot = -1;
        for (int i = 0; i < NUM_ITEMS; i++)
            if (bad_slot < 0 && int'(dut.stock[i]) != m_stock[i]) bad_slot = i;
        n_checks++;
        if (bad_slot >= 0) begin
            n_errors++;
            $display("FAIL stock[%0d]: got %0d, expected %0d", bad_slot,
                     int'(dut.stock[bad_slot]), m_stock[bad_slot]);
        end
        obs_vend += int'(vend);
        obs_inv  += int'(invalid_sel);
        obs_fail += int'(failed_tran);
        if (cost != '0) obs_cost_cyc++;
        if (int'(cost) > obs_max_cost) obs_max_cost = int'(cost);
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] d);
        item_code = d;
        key_press = 1'b1;
        tick(1);
        key_press = 1'b0;
        tick(1);
    endtask

    task automatic do_reload();
        reload = 1'b1; tick(1);
        reload = 1'b0; tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_obs();
        tick(3);
        chk("reset VEND", int'(vend), 0);
        chk("reset COST", int'(cost), 0);
        chk("reset INVALID_SEL", int'(invalid_sel), 0);
        chk("reset stock11", int'(dut.stock[11]), 0);
        reset_n = 1'b1;
        tick(2);

        // reload, select 11, approve, open then close
        do_reload();
        clear_obs();
        card_in = 1'b1; tick(1);
        press(4'd1); press(4'd1);
        tick(1);
        valid_tran = 1'b1; tick(1);
        valid_tran = 1'b0; card_in = 1'b0;
        tick(2);
        door_open = 1'b1; tick(1);
        tick(3);
        door_open = 1'b0; tick(1);
        tick(3);
        chk("vend11 VEND cycles", obs_vend, 7);
        chk("vend11 COST", obs_max_cost, 3);
        chk("vend11 COST cycles", obs_cost_cyc, 8);
        chk("vend11 stock11", int'(dut.stock[11]), 9);

        // reload and card in the same cycle, then select 09
        clear_obs();
        reload = 1'b1; card_in = 1'b1; tick(1);
        reload = 1'b0; tick(1);
        tick(1);
        press(4'd0); press(4'd9);
        tick(1);
        valid_tran = 1'b1; tick(1);
        valid_tran = 1'b0;
        door_open = 1'b1; tick(1);
        door_open = 1'b0; tick(1);
        card_in = 1'b0; tick(3);
        chk("reload+card stock11", int'(dut.stock[11]), 10);
        chk("reload+card stock9", int'(dut.stock[9]), 9);
        chk("reload+card COST", obs_max_cost, 3);
        chk("reload+card VEND cycles", obs_vend, 2);

        // code 21 out of range
        clear_obs();
        card_in = 1'b1; tick(1);
        press(4'd2); press(4'd1);
        tick(2);
        card_in = 1'b0; tick(3);
        chk("code21 INVALID_SEL cycles", obs_inv, 1);
        chk("code21 VEND cycles", obs_vend, 0);
        chk("code21 COST", obs_max_cost, 0);

        // card pulled after first digit
        clear_obs();
        card_in = 1'b1; tick(1);
        press(4'd1);
        card_in = 1'b0; tick(3);
        chk("abort flags", obs_inv + obs_fail, 0);

        // empty slot after reset
        reset_n = 1'b0; tick(2);
        reset_n = 1'b1; tick(1);
        clear_obs();
        card_in = 1'b1; tick(1);
        press(4'd1); press(4'd1);
        tick(2);
        card_in = 1'b0; tick(3);
        chk("empty INVALID_SEL cycles", obs_inv, 1);
        chk("empty stock11", int'(dut.stock[11]), 0);

        // late approval on code 05
        do_reload();
        clear_obs();
        card_in = 1'b1; tick(1);
        press(4'd0); press(4'd5);
        tick(1);
        tick(7);
        card_in = 1'b0; valid_tran = 1'b1; tick(1);
        valid_tran = 1'b0; tick(3);
        chk("late tran FAILED_TRAN cycles", obs_fail, 1);
        chk("late tran COST", obs_max_cost, 2);
        chk("late tran stock5", int'(dut.stock[5]), 10);

        // late first key
        clear_obs();
        card_in = 1'b1; tick(1);
        tick(7);
        card_in = 1'b0;
        press(4'd3);
        tick(3);
        chk("late key FAILED_TRAN cycles", obs_fail, 1);
        chk("late key VEND cycles", obs_vend, 0);

        // late door on code 07
        clear_obs();
        card_in = 1'b1; tick(1);
        press(4'd0); press(4'd7);
        tick(1);
        valid_tran = 1'b1; tick(1);
        valid_tran = 1'b0; card_in = 1'b0;
        tick(7);
        door_open = 1'b1; tick(2);
        door_open = 1'b0; tick(2);
        chk("late door VEND cycles", obs_vend, 6);
        chk("late door flags", obs_inv + obs_fail, 0);
        chk("late door stock7", int'(dut.stock[7]), 10);

        // approval on the last allowed cycle, code 02
        clear_obs();
        card_in = 1'b1; tick(1);
        press(4'd0); press(4'd2);
        tick(1);
        tick(5);
        valid_tran = 1'b1; tick(1);
        valid_tran = 1'b0;
        door_open = 1'b1; tick(1);
        door_open = 1'b0; tick(1);
        card_in = 1'b0; tick(3);
        chk("edge tran FAILED_TRAN cycles", obs_fail, 0);
        chk("edge tran VEND cycles", obs_vend, 2);
        chk("edge tran COST", obs_max_cost, 1);
        chk("edge tran stock2", int'(dut.stock[2]), 9);

        // code 00 with the door held open, then reset
        clear_obs();
        card_in = 1'b1; tick(1);
        press(4'd0); press(4'd0);
        tick(1);
        valid_tran = 1'b1; tick(1);
        valid_tran = 1'b0;
        door_open = 1'b1; tick(1);
        tick(20);
        chk("held door VEND", int'(vend), 1);
        chk("held door stock0", int'(dut.stock[0]), 10);
        reset_n = 1'b0;
        #1;
        chk("reset VEND immediate", int'(vend), 0);
        chk("reset stock0", int'(dut.stock[0]), 0);
        tick(2);
        door_open = 1'b0; card_in = 1'b0;
        reset_n = 1'b1;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
